// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: converts a U(9,7) degree angle into signed Q2.14 cos/sin.
// One micro-rotation per clock with valid/ready handshakes on both the input and output sides.
module cordic_sincos #(
    parameter int WORD_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int ITERATIONS  = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PHASE_WIDTH-1:0] angle_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  cos_out,
    output logic [WORD_WIDTH-1:0]  sin_out
);
    localparam int XW  = WORD_WIDTH + 2;
    localparam int ZW  = PHASE_WIDTH + 1;
    localparam int ITW = $clog2(ITERATIONS);

    localparam logic [PHASE_WIDTH-1:0] DEG90  = PHASE_WIDTH'(11520);
    localparam logic [PHASE_WIDTH-1:0] DEG180 = PHASE_WIDTH'(23040);
    localparam logic [PHASE_WIDTH-1:0] DEG270 = PHASE_WIDTH'(34560);
    localparam logic [PHASE_WIDTH-1:0] DEG360 = PHASE_WIDTH'(46080);
    localparam logic [ITW-1:0]         ITER_LAST = ITW'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Elementary angles atan(2^-i) in U(9,7) degrees.
    function automatic logic signed [ZW-1:0] atan_lut(input logic [ITW-1:0] i);
        case (i)
            4'd0:    atan_lut = ZW'(5760);
            4'd1:    atan_lut = ZW'(3400);
            4'd2:    atan_lut = ZW'(1797);
            4'd3:    atan_lut = ZW'(912);
            4'd4:    atan_lut = ZW'(458);
            4'd5:    atan_lut = ZW'(229);
            4'd6:    atan_lut = ZW'(115);
            4'd7:    atan_lut = ZW'(57);
            4'd8:    atan_lut = ZW'(29);
            4'd9:    atan_lut = ZW'(14);
            4'd10:   atan_lut = ZW'(7);
            4'd11:   atan_lut = ZW'(4);
            4'd12:   atan_lut = ZW'(2);
            4'd13:   atan_lut = ZW'(1);
            default: atan_lut = ZW'(0);
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]    z_q, z_d;
    logic [ITW-1:0]          iter_q, iter_d;
    logic [1:0]              quad_q, quad_d;
    logic                    out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0]   cos_q, cos_d, sin_q, sin_d;

    logic [PHASE_WIDTH-1:0]  wrap_s, resid_s;
    logic [1:0]              quad_s;
    logic signed [XW-1:0]    x_rot_s, y_rot_s, x_neg_s, y_neg_s;
    logic signed [ZW-1:0]    z_rot_s;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;

    // Angle reduction to a quadrant plus residual in [0, 90) degrees.
    always_comb begin
        if (angle_in >= DEG360) begin
            wrap_s = angle_in - DEG360;
        end else begin
            wrap_s = angle_in;
        end
        if (wrap_s < DEG90) begin
            quad_s  = 2'd0;
            resid_s = wrap_s;
        end else if (wrap_s < DEG180) begin
            quad_s  = 2'd1;
            resid_s = wrap_s - DEG90;
        end else if (wrap_s < DEG270) begin
            quad_s  = 2'd2;
            resid_s = wrap_s - DEG180;
        end else begin
            quad_s  = 2'd3;
            resid_s = wrap_s - DEG270;
        end
    end

    // Next-state, micro-rotation and output mapping.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        quad_d      = quad_q;
        out_valid_d = out_valid_q;
        cos_d       = cos_q;
        sin_d       = sin_q;

        if (z_q[ZW-1] == 1'b0) begin
            x_rot_s = x_q - (y_q >>> iter_q);
            y_rot_s = y_q + (x_q >>> iter_q);
            z_rot_s = z_q - atan_lut(iter_q);
        end else begin
            x_rot_s = x_q + (y_q >>> iter_q);
            y_rot_s = y_q - (x_q >>> iter_q);
            z_rot_s = z_q + atan_lut(iter_q);
        end
        x_neg_s = -x_rot_s;
        y_neg_s = -y_rot_s;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ROTATE;
                    x_d     = XW'(9949);
                    y_d     = '0;
                    z_d     = {1'b0, resid_s};
                    iter_d  = '0;
                    quad_d  = quad_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ROTATE: begin
                x_d = x_rot_s;
                y_d = y_rot_s;
                z_d = z_rot_s;
                if (iter_q == ITER_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    case (quad_q)
                        2'd0: begin
                            cos_d = x_rot_s[WORD_WIDTH-1:0];
                            sin_d = y_rot_s[WORD_WIDTH-1:0];
                        end
                        2'd1: begin
                            cos_d = y_neg_s[WORD_WIDTH-1:0];
                            sin_d = x_rot_s[WORD_WIDTH-1:0];
                        end
                        2'd2: begin
                            cos_d = x_neg_s[WORD_WIDTH-1:0];
                            sin_d = y_neg_s[WORD_WIDTH-1:0];
                        end
                        default: begin
                            cos_d = y_rot_s[WORD_WIDTH-1:0];
                            sin_d = x_neg_s[WORD_WIDTH-1:0];
                        end
                    endcase
                end else begin
                    iter_d = iter_q + ITW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            quad_q      <= 2'd0;
            out_valid_q <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            quad_q      <= quad_d;
            out_valid_q <= out_valid_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
        end
    end
endmodule
